fx3_slfifo_writer: RTL and testbench

- FPGA-to-host write controller for the FX3 synchronous slave FIFO. This is the transmit counterpart of the existing slave-FIFO read controller.
- Drains a local first-word-fall-through (FWFT) source FIFO into the FX3 write socket in fixed bursts.
- Issues only burst writes, gated by the FX3 ready flag (FLAGA) and watermark flag (FLAGB).
- Sits between the DA/ADC capture FIFO and the FX3 GPIF pins; it shares the pins with the reader, which is arbitrated by the enable input.

---
 rtl/fx3_slfifo_writer_if.sv | 30 +++
 rtl/fx3_slfifo_writer.sv | 177 +++++++++++++++++
 tb/tb_fx3_slfifo_writer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fx3_slfifo_writer_if.sv
// FX3 slave-FIFO write-side bundle: GPIF pins plus the FWFT source FIFO port.
// master = the write controller, slave = the pin/FIFO side (or a testbench).
interface fx3_slfifo_writer_if #(
  parameter int DATA_W = 32
);
  logic              FLAGA;
  logic              FLAGB;
  logic [DATA_W-1:0] src_data;
  logic              src_avail;
  logic              src_empty;
  logic              src_rd;
  logic              SLCS;
  logic              SLWR;
  logic              SLOE;
  logic              PKTEND;
  logic              A1;
  logic              A0;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;

  modport master (
    input  FLAGA, FLAGB, src_data, src_avail, src_empty,
    output src_rd, SLCS, SLWR, SLOE, PKTEND, A1, A0, dq_out, dq_oe
  );

  modport slave (
    output FLAGA, FLAGB, src_data, src_avail, src_empty,
    input  src_rd, SLCS, SLWR, SLOE, PKTEND, A1, A0, dq_out, dq_oe
  );
endinterface

// File: rtl/fx3_slfifo_writer.sv
// FX3 synchronous slave-FIFO write controller. Drains an FWFT source FIFO
// into the FX3 write socket in fixed bursts gated by FLAGA / FLAGB.
// Optional macro FX3_WR_SHORT_PKT_EN adds a WAIT_RDY idle timer and a FLUSH
// state that empties a partial source and closes the packet with PKTEND.
module fx3_slfifo_writer #(
  parameter int         DATA_W    = 32,
  parameter int         BURST_LEN = 256,
  parameter logic [1:0] ADDR_WR   = 2'b00,
  parameter int         FLAG_LAT  = 3,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  fx3_slfifo_writer_if.master bus,
  output logic [31:0]         usb_wr_cnt,
  output logic [2:0]          usb_wr_state
);

  if (BURST_LEN < 4 || FLAG_LAT < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("fx3_slfifo_writer: BURST_LEN >= 4, FLAG_LAT >= 1, TIMEOUT >= 1 required");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    WAIT_RDY = 3'd2,
    BURST    = 3'd3,
    TAIL     = 3'd4
`ifdef FX3_WR_SHORT_PKT_EN
    , FLUSH  = 3'd5
`endif
  } state_t;

  localparam int BCNT_W = $clog2(BURST_LEN + 1);
  localparam int LAT_W  = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN);
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(FLAG_LAT - 1);

  state_t            state;
  logic [BCNT_W-1:0] burst_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              flagb_m;
  logic              flagb_s;

`ifdef FX3_WR_SHORT_PKT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);
  logic [TMR_W-1:0] timer;
`endif

  assign usb_wr_state = state;

  // Two-flop resynchronizer for the FX3 watermark flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flagb_m <= 1'b1;
      flagb_s <= 1'b1;
    end else begin
      flagb_m <= bus.FLAGB;
      flagb_s <= flagb_m;
    end
  end

  // Write FSM with registered pin outputs. A write cycle registers SLWR=0,
  // src_rd=1 and the FWFT head together, so the popped word is on DQ in the
  // same cycle as its strobe. Strobes default high/low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      lat_cnt     <= '0;
      usb_wr_cnt  <= '0;
      bus.SLCS    <= 1'b1;
      bus.SLWR    <= 1'b1;
      bus.SLOE    <= 1'b1;
      bus.PKTEND  <= 1'b1;
      bus.A1      <= 1'b1;
      bus.A0      <= 1'b1;
      bus.dq_out  <= {DATA_W{1'b0}};
      bus.dq_oe   <= 1'b0;
      bus.src_rd  <= 1'b0;
`ifdef FX3_WR_SHORT_PKT_EN
      timer       <= '0;
`endif
    end else begin
      bus.SLWR   <= 1'b1;
      bus.src_rd <= 1'b0;
      bus.PKTEND <= 1'b1;
      bus.SLOE   <= 1'b1;
`ifdef FX3_WR_SHORT_PKT_EN
      timer      <= '0;
`endif
      case (state)
        IDLE: begin
          if (enable) begin
            state              <= ADDR;
            lat_cnt            <= '0;
            bus.SLCS           <= 1'b0;
            {bus.A1, bus.A0}   <= ADDR_WR;
            bus.dq_oe          <= 1'b1;
          end
        end
        ADDR: begin
          if (lat_cnt == LAT_LAST) state <= WAIT_RDY;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        WAIT_RDY: begin
          if (!enable) begin
            state            <= IDLE;
            bus.SLCS         <= 1'b1;
            {bus.A1, bus.A0} <= 2'b11;
            bus.dq_oe        <= 1'b0;
            bus.dq_out       <= {DATA_W{1'b0}};
          end else if (bus.FLAGA && flagb_s && bus.src_avail) begin
            state       <= BURST;
            bus.SLWR    <= 1'b0;
            bus.src_rd  <= 1'b1;
            bus.dq_out  <= bus.src_data;
            usb_wr_cnt  <= usb_wr_cnt + 1'b1;
            burst_cnt   <= BCNT_W'(1);
          end
`ifdef FX3_WR_SHORT_PKT_EN
          else if (!bus.src_avail && !bus.src_empty) begin
            if (timer == TMR_LAST) begin
              if (bus.FLAGA) state <= FLUSH;
              else           timer <= timer;
            end else begin
              timer <= timer + 1'b1;
            end
          end
`endif
        end
        BURST: begin
          // Exit on full burst, watermark or source underrun; the exit cycle
          // never strobes, so a burst cut by FLAGB loses no popped word.
          if (burst_cnt == BURST_LAST || !flagb_s || bus.src_empty) begin
            state     <= TAIL;
            lat_cnt   <= '0;
            burst_cnt <= '0;
          end else begin
            bus.SLWR   <= 1'b0;
            bus.src_rd <= 1'b1;
            bus.dq_out <= bus.src_data;
            usb_wr_cnt <= usb_wr_cnt + 1'b1;
            burst_cnt  <= burst_cnt + 1'b1;
          end
        end
        TAIL: begin
          if (lat_cnt == LAT_LAST) state <= WAIT_RDY;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
`ifdef FX3_WR_SHORT_PKT_EN
        FLUSH: begin
          // The source only reports empty, not "one left", so the packet is
          // closed by a standalone PKTEND once the source runs dry.
          if (bus.src_empty) begin
            bus.PKTEND <= 1'b0;
            state      <= TAIL;
            lat_cnt    <= '0;
          end else if (!flagb_s) begin
            state   <= TAIL;
            lat_cnt <= '0;
          end else begin
            bus.SLWR   <= 1'b0;
            bus.src_rd <= 1'b1;
            bus.dq_out <= bus.src_data;
            usb_wr_cnt <= usb_wr_cnt + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx3_slfifo_writer.sv
// Directed self-checking bench for fx3_slfifo_writer (default build).
// The source FIFO model holds word n = n; while src_rd is high the head
// already shows the following word, so each strobed cycle pops exactly the
// word on DQ.
module tb_fx3_slfifo_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] usb_wr_cnt;
  logic [2:0]  usb_wr_state;

  int          vectors = 0;
  int          miscompares = 0;
  int          align_err = 0;
  logic [31:0] last_wr = '0;
  logic [31:0] rd_ptr = '0;

  fx3_slfifo_writer_if #(.DATA_W(32)) bus ();

  fx3_slfifo_writer #(
    .DATA_W   (32),
    .BURST_LEN(256),
    .ADDR_WR  (2'b00),
    .FLAG_LAT (3),
    .TIMEOUT  (1024)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .bus         (bus),
    .usb_wr_cnt  (usb_wr_cnt),
    .usb_wr_state(usb_wr_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.src_rd === 1'b1) rd_ptr <= rd_ptr + 1;
  assign bus.src_data = rd_ptr + {31'd0, bus.src_rd};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, got, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (bus.SLWR === 1'b0) last_wr = bus.dq_out;
      if (bus.src_rd !== ~bus.SLWR) align_err++;
    end
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(bus.SLWR === 1'b0 && bus.dq_out === w) && n < 2000);
    chk(tag, {31'd0, (bus.SLWR === 1'b0 && bus.dq_out === w)}, 1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int n = 0;
    do begin
      step();
      n++;
    end while (usb_wr_state !== st && n < 2000);
    chk(tag, {29'd0, usb_wr_state}, {29'd0, st});
  endtask

  initial begin
    int n;
    int nw;
    bus.FLAGA = 1'b1;
    bus.FLAGB = 1'b1;
    bus.src_avail = 1'b1;
    bus.src_empty = 1'b0;
    repeat (3) step();

    chk("rst_state",  {29'd0, usb_wr_state}, 0);
    chk("rst_slcs",   {31'd0, bus.SLCS}, 1);
    chk("rst_slwr",   {31'd0, bus.SLWR}, 1);
    chk("rst_sloe",   {31'd0, bus.SLOE}, 1);
    chk("rst_pktend", {31'd0, bus.PKTEND}, 1);
    chk("rst_addr",   {30'd0, bus.A1, bus.A0}, 3);
    chk("rst_dq_oe",  {31'd0, bus.dq_oe}, 0);
    chk("rst_src_rd", {31'd0, bus.src_rd}, 0);
    chk("rst_dq",     bus.dq_out, 0);
    chk("rst_cnt",    usb_wr_cnt, 0);

    rst_n = 1'b1;
    repeat (2) step();

    // Full burst from enable
    enable = 1'b1;
    step();
    chk("addr_a",     {30'd0, bus.A1, bus.A0}, 0);
    chk("addr_slcs",  {31'd0, bus.SLCS}, 0);
    chk("addr_dq_oe", {31'd0, bus.dq_oe}, 1);
    chk("addr_state", {29'd0, usb_wr_state}, 1);
    n = 1;
    while (bus.SLWR !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("first_wr_lat", n, 5);
    for (int i = 0; i < 256; i++) begin
      chk("burst_slwr", {31'd0, bus.SLWR}, 0);
      chk("burst_dq", bus.dq_out, i);
      step();
    end
    chk("burst_end_slwr", {31'd0, bus.SLWR}, 1);
    chk("burst_cnt",      usb_wr_cnt, 256);
    chk("burst_tail",     {29'd0, usb_wr_state}, 4);

    // FLAGA low holds WAIT_RDY
    bus.FLAGA = 1'b0;
    nw = 0;
    repeat (10) begin
      step();
      if (bus.SLWR === 1'b0) nw++;
    end
    chk("flaga0_nowr",  nw, 0);
    chk("flaga0_state", {29'd0, usb_wr_state}, 2);
    bus.FLAGA = 1'b1;
    step();
    chk("flaga1_slwr", {31'd0, bus.SLWR}, 0);
    chk("flaga1_dq",   bus.dq_out, 256);

    // FLAGB drop at burst word 100 (absolute 356)
    wait_word("reach_356", 356);
    bus.FLAGB = 1'b0;
    n = 0;
    while (bus.SLWR === 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("flagb_stop_lat", n, 3);
    chk("flagb_last",     last_wr, 358);
    chk("flagb_nopop",    {31'd0, bus.src_rd}, 0);
    chk("flagb_cnt",      usb_wr_cnt, 359);
    chk("flagb_tail",     {29'd0, usb_wr_state}, 4);
    nw = 0;
    repeat (6) begin
      step();
      if (bus.SLWR === 1'b0) nw++;
    end
    chk("flagb_hold_nowr",  nw, 0);
    chk("flagb_hold_state", {29'd0, usb_wr_state}, 2);
    bus.FLAGB = 1'b1;
    wait_word("resume_359", 359);
    chk("resume_cnt", usb_wr_cnt, 360);

    // enable drop mid-burst: burst still completes (359..614)
    wait_word("reach_409", 409);
    enable = 1'b0;
    wait_state("en0_idle", 3'd0);
    chk("en0_last",  last_wr, 614);
    chk("en0_cnt",   usb_wr_cnt, 615);
    chk("en0_addr",  {30'd0, bus.A1, bus.A0}, 3);
    chk("en0_dq_oe", {31'd0, bus.dq_oe}, 0);
    chk("en0_slcs",  {31'd0, bus.SLCS}, 1);
    repeat (5) step();
    chk("en0_quiet_cnt", usb_wr_cnt, 615);

    // Asynchronous reset at burst word 10 (absolute 625)
    enable = 1'b1;
    wait_word("reach_625", 625);
    rst_n = 1'b0;
    #1;
    chk("arst_slwr",   {31'd0, bus.SLWR}, 1);
    chk("arst_slcs",   {31'd0, bus.SLCS}, 1);
    chk("arst_src_rd", {31'd0, bus.src_rd}, 0);
    chk("arst_pktend", {31'd0, bus.PKTEND}, 1);
    chk("arst_addr",   {30'd0, bus.A1, bus.A0}, 3);
    chk("arst_dq_oe",  {31'd0, bus.dq_oe}, 0);
    chk("arst_dq",     bus.dq_out, 0);
    chk("arst_cnt",    usb_wr_cnt, 0);
    chk("arst_state",  {29'd0, usb_wr_state}, 0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_word("post_rst_625", 625);
    chk("post_rst_cnt", usb_wr_cnt, 1);

    // Source underrun: stop without popping
    wait_word("reach_630", 630);
    bus.src_empty = 1'b1;
    step();
    chk("empty_slwr",  {31'd0, bus.SLWR}, 1);
    chk("empty_rd",    {31'd0, bus.src_rd}, 0);
    chk("empty_state", {29'd0, usb_wr_state}, 4);
    chk("empty_last",  last_wr, 630);
    chk("empty_cnt",   usb_wr_cnt, 6);
    bus.src_empty = 1'b0;

    // FLAGB_s low exactly at the final burst word: that word is not written
    wait_word("reach_631", 631);
    wait_word("reach_883", 883);
    bus.FLAGB = 1'b0;
    n = 0;
    while (bus.SLWR === 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("fbfinal_last",  last_wr, 885);
    chk("fbfinal_state", {29'd0, usb_wr_state}, 4);
    chk("fbfinal_cnt",   usb_wr_cnt, 261);
    bus.FLAGB = 1'b1;
    enable = 1'b0;
    wait_state("final_idle", 3'd0);
    chk("rd_wr_align", align_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
